data_memory_pipe: RTL and testbench
===================================

DATA_MEMORY_PIPE -- requirements
Module: data_memory_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 16, data word width in bits (multiple of 8, min 16).
REQ-002 SHALL have parameter DEPTH, default 256, number of words (power of two).
REQ-003 SHALL have parameter ADDR_W, default 16, byte-address width.
REQ-004 SHALL have parameter LATENCY, default 2, read latency in cycles (legal 1..4).
REQ-005 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have port req_valid, input, 1, request present.
REQ-008 SHALL have port req_ready, output, 1, request accepted this cycle when high with req_valid.
REQ-009 SHALL have port req_write, input, 1, 1 = write, 0 = read.
REQ-010 SHALL have port req_addr, input, ADDR_W, byte address.
REQ-011 SHALL have port req_wdata, input, DATA_W, write data.
REQ-012 SHALL have port req_be, input, DATA_W/8, per-byte write enable.
REQ-013 SHALL have port rsp_valid, output, 1, read response present.
REQ-014 SHALL have port rsp_ready, input, 1, consumer takes the response when high with rsp_valid.
REQ-015 SHALL have port rsp_rdata, output, DATA_W, read data.
REQ-016 SHALL have port rsp_err, output, 1, the request was out of range or misaligned.

Function
REQ-017 SHALL compute word index = req_addr[LSB +: log2(DEPTH)], where LSB = log2(DATA_W/8).
REQ-018 SHALL flag a request as erroneous if any of req_addr[LSB-1:0] is nonzero or any address bit above the index is nonzero.
REQ-019 SHALL treat a request as accepted in a cycle where req_valid && req_ready.
REQ-020 SHALL, on an accepted non-erroneous write, update only the bytes whose req_be bit is set, at that clock edge; writes produce no response.
REQ-021 SHALL suppress erroneous writes entirely; memory is unchanged.
REQ-022 SHALL, for a read accepted at edge N, present rsp_valid with its data at edge N+LATENCY-1, absent stalls (LATENCY=1: response visible the cycle after accept).
REQ-023 SHALL, for an erroneous read, return rsp_rdata = 0 and rsp_err = 1; otherwise rsp_err = 0.
REQ-024 SHALL sample read data from the array at the accept edge, so a write accepted later never alters an in-flight read; a write accepted at edge N is visible to a read accepted at edge N+1.
REQ-025 SHALL stall the whole response pipeline (all stages hold) while rsp_valid && !rsp_ready.
REQ-026 SHALL drive req_ready = !(rsp_valid && !rsp_ready); reads and writes are both blocked during a stall.
REQ-027 SHALL hold rsp_rdata and rsp_err stable while rsp_valid && !rsp_ready.
REQ-028 SHALL insert a bubble (valid = 0) into the pipeline for a cycle with no accepted read, including accepted writes.
REQ-029 SHALL sustain one accepted request per cycle when rsp_ready is held high.

Reset
REQ-030 SHALL, while rst is high, clear all pipeline valid bits; rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, req_ready = 1 in the following cycle.
REQ-031 SHALL discard in-flight reads on reset; no response is delivered for them.
REQ-032 SHALL ignore requests presented in a cycle with rst high (no write occurs).
REQ-033 SHALL NOT clear array contents on reset; array initialises to all zeros at time zero only.

Structure
REQ-034 SHALL place the default parameter constants and a response struct typedef (valid, rdata, err) in package data_memory_pkg.
REQ-035 SHALL implement the stallable LATENCY-stage response shift pipeline as sub-module rsp_pipe, instantiated once.

Verification
REQ-036 SHALL cover the following scenario: write 0xBEEF to byte address 0x0004 with be=11, then read 0x0004 the next cycle -> at LATENCY=2, rsp_valid rises 1 cycle after the read accept with rdata 0xBEEF and err 0.
REQ-037 SHALL cover the following scenario: write 0x1234 to address 0x0010 with be=11, write 0xAB00 with be=10, then read -> rdata 0xAB34.
REQ-038 SHALL cover the following scenario: read address 0x0201 (misaligned) and 0x0200 (out of range, DEPTH=256) -> two responses, each with rdata 0 and err 1; a write to 0x0200 leaves word 0 unchanged.
REQ-039 SHALL cover the following scenario: issue back-to-back reads of addresses 0, 2, 4 with rsp_ready low for 3 cycles after the first response -> req_ready low during the stall, responses held stable, then all three delivered in order with no loss or duplication.
REQ-040 SHALL cover the following scenario: read address 0x0006, then write 0x5555 to 0x0006 in the next cycle -> the read returns the old value.
REQ-041 SHALL cover the following scenario: assert rst for 1 cycle with two reads in flight -> no responses delivered, rsp_valid = 0, req_ready = 1, and previously written data is still readable.

Source files
------------

// File: rtl/data_memory_pkg.sv
// rtl/data_memory_pkg.sv - shared constants and response record for data_memory_pipe
// Purpose : default parameter values and the response struct carried down the
//           read pipeline.
// Ports   : none (package).
package data_memory_pkg;

  localparam int DATA_W_DEF  = 16;
  localparam int DEPTH_DEF   = 256;
  localparam int ADDR_W_DEF  = 16;
  localparam int LATENCY_DEF = 2;

  // Widest data word the pipeline record can carry; narrower words are
  // zero-extended into it.
  localparam int DATA_W_MAX  = 64;

  typedef struct packed {
    logic                  valid;
    logic [DATA_W_MAX-1:0] rdata;
    logic                  err;
  } rsp_t;

endpackage

// File: rtl/data_memory_pipe_rsp_pipe.sv
// rtl/data_memory_pipe_rsp_pipe.sv - stallable LATENCY-stage response shift pipeline
// Purpose : carries read responses from the accept edge to the output; the
//           whole pipeline freezes while the head is valid and not taken.
// Ports   : clk, rst        - clock, synchronous active-high reset
//           rsp_ready       - consumer takes head this cycle when high
//           push            - record loaded into stage 0 (valid=0 is a bubble)
//           head            - last stage, drives the response outputs
module rsp_pipe
  import data_memory_pkg::*;
#(
  parameter int LATENCY = LATENCY_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic rsp_ready,
  input  rsp_t push,
  output rsp_t head
);

  rsp_t stage [LATENCY];
  logic hold;

  assign hold = stage[LATENCY-1].valid && !rsp_ready;
  assign head = stage[LATENCY-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LATENCY; i++) begin
        stage[i] <= '0;
      end
    end else if (!hold) begin
      stage[0] <= push;
      for (int i = 1; i < LATENCY; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

endmodule

// File: rtl/data_memory_pipe.sv
// rtl/data_memory_pipe.sv - byte-enabled word memory with pipelined, stallable reads
// Purpose : single-port data memory; writes land at the accept edge, reads are
//           sampled at the accept edge and returned LATENCY-1 cycles later.
// Ports   : clk, rst                      - clock, synchronous active-high reset
//           req_valid/req_ready           - request handshake
//           req_write, req_addr           - 1 = write; byte address
//           req_wdata, req_be             - write data and per-byte enables
//           rsp_valid/rsp_ready           - read response handshake
//           rsp_rdata, rsp_err            - read data; out-of-range/misaligned flag
module data_memory_pipe
  import data_memory_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int LATENCY = LATENCY_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err
);

  localparam int NB    = DATA_W / 8;
  localparam int LSB   = $clog2(NB);
  localparam int IDX_W = $clog2(DEPTH);

  // Contents survive reset; only the power-on value is zero.
  logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

  logic [IDX_W-1:0] word_idx;
  logic             addr_err;
  logic             accept;
  rsp_t             push;
  rsp_t             head;
  logic             unused_rdata;

  assign word_idx = req_addr[LSB +: IDX_W];
  assign addr_err = (req_addr[LSB-1:0] != '0) ||
                    ((req_addr >> (LSB + IDX_W)) != '0);

  // Requests seen while rst is high are ignored, whatever req_ready shows.
  assign accept    = req_valid && req_ready && !rst;
  assign req_ready = !(head.valid && !rsp_ready);

  always_ff @(posedge clk) begin
    if (accept && req_write && !addr_err) begin
      for (int b = 0; b < NB; b++) begin
        if (req_be[b]) begin
          mem[word_idx][b*8 +: 8] <= req_wdata[b*8 +: 8];
        end
      end
    end
  end

  // Array is read here, before the edge, so later writes cannot reach an
  // in-flight read; writes and idle cycles enter the pipe as bubbles.
  always_comb begin
    push       = '0;
    push.valid = accept && !req_write;
    push.err   = addr_err;
    push.rdata = addr_err ? '0 : DATA_W_MAX'(mem[word_idx]);
  end

  rsp_pipe #(
    .LATENCY (LATENCY)
  ) u_rsp_pipe (
    .clk       (clk),
    .rst       (rst),
    .rsp_ready (rsp_ready),
    .push      (push),
    .head      (head)
  );

  assign rsp_valid    = head.valid;
  assign rsp_rdata    = head.rdata[DATA_W-1:0];
  assign rsp_err      = head.err;
  assign unused_rdata = ^head.rdata;

endmodule

// File: tb/tb_data_memory_pipe.sv
// tb/tb_data_memory_pipe.sv - directed scoreboard bench for data_memory_pipe
module tb_data_memory_pipe;

  localparam int DATA_W  = 16;
  localparam int DEPTH   = 256;
  localparam int ADDR_W  = 16;
  localparam int LATENCY = 2;

  logic              clk = 0;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [1:0]        req_be;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  int passed = 0;
  int total  = 0;
  int fails  = 0;

  logic [15:0] model [DEPTH];
  logic [16:0] exp_q [$];   // {err, rdata}

  data_memory_pipe #(
    .DATA_W  (DATA_W),
    .DEPTH   (DEPTH),
    .ADDR_W  (ADDR_W),
    .LATENCY (LATENCY)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Consumer side: every delivered response must match the head of the queue.
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_rsp", 32'(exp_q.size()), 32'd1);
      end else begin
        logic [16:0] e;
        e = exp_q.pop_front();
        check("rsp_rdata", 32'(rsp_rdata), 32'(e[15:0]));
        check("rsp_err", 32'(rsp_err), 32'(e[16]));
      end
    end
  end

  // Drives one request, waits for acceptance, updates model/scoreboard.
  // Returns 1 time unit after the accept edge with req_valid still high.
  task automatic do_req(input logic wr, input logic [15:0] addr,
                        input logic [15:0] wd, input logic [1:0] be);
    int   waited = 0;
    logic err;
    logic [7:0] idx;
    req_valid = 1; req_write = wr; req_addr = addr; req_wdata = wd; req_be = be;
    forever begin
      @(negedge clk);
      if (req_ready) break;
      waited++;
      if (waited > 50) begin
        check("req_accept_timeout", 32'(waited), 32'd0);
        req_valid = 0;
        return;
      end
      @(posedge clk);
    end
    @(posedge clk);
    err = addr[0] || (addr[15:9] != 7'd0);
    idx = addr[8:1];
    if (wr) begin
      if (!err) begin
        if (be[0]) model[idx][7:0]  = wd[7:0];
        if (be[1]) model[idx][15:8] = wd[15:8];
      end
    end else begin
      exp_q.push_back(err ? 17'h10000 : {1'b0, model[idx]});
    end
    #1;
  endtask

  task automatic idle();
    req_valid = 0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    rst = 1; req_valid = 0; req_write = 0; req_addr = '0; req_wdata = '0;
    req_be = '0; rsp_ready = 1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_req_ready", 32'(req_ready), 32'd1);
    check("reset_rsp_rdata", 32'(rsp_rdata), 32'd0);
    check("reset_rsp_err", 32'(rsp_err), 32'd0);
    rst = 0;
    @(posedge clk); #1;

    // Write then read next cycle; response one cycle after read accept.
    do_req(1, 16'h0004, 16'hBEEF, 2'b11);
    do_req(0, 16'h0004, 16'h0000, 2'b00);
    idle();
    check("lat_not_yet", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    check("lat_valid", 32'(rsp_valid), 32'd1);
    check("lat_rdata", 32'(rsp_rdata), 32'h0000BEEF);
    wait_drain();

    // Byte-enable merge.
    do_req(1, 16'h0010, 16'h1234, 2'b11);
    do_req(1, 16'h0010, 16'hAB00, 2'b10);
    do_req(0, 16'h0010, 16'h0000, 2'b00);
    idle();
    wait_drain();
    check("be_merge_model", 32'(model[8]), 32'h0000AB34);

    // Misaligned / out of range; suppressed write must not alias to word 0.
    do_req(1, 16'h0000, 16'hCAFE, 2'b11);
    do_req(0, 16'h0201, 16'h0000, 2'b00);
    do_req(0, 16'h0200, 16'h0000, 2'b00);
    do_req(1, 16'h0200, 16'hFFFF, 2'b11);
    do_req(0, 16'h0000, 16'h0000, 2'b00);
    idle();
    wait_drain();

    // Back-to-back reads with a 3-cycle consumer stall after the first response.
    do_req(1, 16'h0002, 16'h2222, 2'b11);
    idle();
    @(posedge clk); #1;
    do_req(0, 16'h0000, 16'h0000, 2'b00);
    do_req(0, 16'h0002, 16'h0000, 2'b00);
    rsp_ready = 0;
    fork
      do_req(0, 16'h0004, 16'h0000, 2'b00);
      begin
        for (int c = 0; c < 3; c++) begin
          @(negedge clk);
          check("stall_valid", 32'(rsp_valid), 32'd1);
          check("stall_rdata", 32'(rsp_rdata), 32'h0000CAFE);
          check("stall_req_ready", 32'(req_ready), 32'd0);
          @(posedge clk);
        end
        #1;
        rsp_ready = 1;
      end
    join
    idle();
    wait_drain();

    // Read-before-write ordering.
    do_req(1, 16'h0006, 16'h7777, 2'b11);
    do_req(0, 16'h0006, 16'h0000, 2'b00);
    do_req(1, 16'h0006, 16'h5555, 2'b11);
    do_req(0, 16'h0006, 16'h0000, 2'b00);
    idle();
    wait_drain();

    // Reset with two reads in flight; a write during reset is ignored.
    do_req(0, 16'h0004, 16'h0000, 2'b00);
    do_req(0, 16'h0006, 16'h0000, 2'b00);
    rsp_ready = 0;
    rst = 1;
    req_write = 1; req_addr = 16'h0006; req_wdata = 16'hDEAD; req_be = 2'b11;
    @(posedge clk);
    exp_q.delete();
    #1;
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    rst = 0; req_valid = 0; rsp_ready = 1;
    repeat (4) @(posedge clk);
    #1;
    check("rst_no_rsp", 32'(rsp_valid), 32'd0);
    do_req(0, 16'h0006, 16'h0000, 2'b00);
    do_req(0, 16'h0004, 16'h0000, 2'b00);
    idle();
    wait_drain();
    check("rst_model_kept", 32'(model[3]), 32'h00005555);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
